// File: rtl/roundpack_add_arbiter_if.sv
// Requester/result bus and core-side bus for the shared roundAndPackFloat64_add arbiter.
// On the requester bus the arbiter is the slave; on the core bus the arbiter is the master.
interface roundpack_req_if #(
    parameter int N_REQ  = 4,
    parameter int FLAG_W = 32
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    req_sign;
    logic [12*N_REQ-1:0] req_exp;
    logic [64*N_REQ-1:0] req_sig;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_data;
    logic [FLAG_W-1:0]   rsp_flags;
    logic [FLAG_W-1:0]   flag_q;
    logic                flag_clr;

    modport master (
        output req_valid, req_sign, req_exp, req_sig, rsp_ready, flag_clr,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, flag_q
    );
    modport slave (
        input  req_valid, req_sign, req_exp, req_sig, rsp_ready, flag_clr,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags, flag_q
    );
endinterface

interface roundpack_core_if #(
    parameter int FLAG_W = 32
);
    logic              u_ap_start;
    logic              u_ap_done;
    logic              u_ap_idle;
    logic              u_ap_ready;
    logic              u_zSign;
    logic [11:0]       u_zExp;
    logic [63:0]       u_zSig;
    logic [FLAG_W-1:0] u_flag_i;
    logic [FLAG_W-1:0] u_flag_o;
    logic              u_flag_o_vld;
    logic [63:0]       u_ap_return;

    modport master (
        output u_ap_start, u_zSign, u_zExp, u_zSig, u_flag_i,
        input  u_ap_done, u_ap_idle, u_ap_ready, u_flag_o, u_flag_o_vld, u_ap_return
    );
    modport slave (
        input  u_ap_start, u_zSign, u_zExp, u_zSig, u_flag_i,
        output u_ap_done, u_ap_idle, u_ap_ready, u_flag_o, u_flag_o_vld, u_ap_return
    );
endinterface

// File: rtl/roundpack_add_arbiter.sv
// Round-robin arbiter sharing one roundAndPackFloat64_add core (ap_ctrl_hs) among N_REQ
// requesters; owns the sticky exception-flag register and tags each result with its owner.

// Per-requester operand lane: forwards its operands only when granted, so the
// lanes can be OR-reduced into a single operand bundle.
module roundpack_req_slice (
    input  logic        sel,
    input  logic        sign,
    input  logic [11:0] exp,
    input  logic [63:0] sig,
    output logic [76:0] op
);
    assign op = sel ? {sign, exp, sig} : '0;
endmodule

module roundpack_add_arbiter #(
    parameter int N_REQ  = 4,
    parameter int FLAG_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    roundpack_req_if.slave    req_bus,
    roundpack_core_if.master  core
);
    localparam int IDW = $clog2(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state, state_nx;
    logic [IDW-1:0]       last_grant, gnt_idx, gnt_q;
    logic [N_REQ-1:0]     gnt_oh;
    logic                 any_req;
    logic                 accept, cap_done, rsp_hs, flag_wb;
    logic                 ap_start, rsp_valid;
    logic [N_REQ-1:0][76:0] lane_op;
    logic [76:0]          sel_op;
    logic                 z_sign;
    logic [11:0]          z_exp;
    logic [63:0]          z_sig;
    logic [FLAG_W-1:0]    flag_q, flag_snap, rsp_flags;
    logic [63:0]          rsp_data;
    logic                 unused_core_idle;

    // First requesting index after the last winner, wrapping around.
    always_comb begin
        logic [IDW-1:0] iv;
        gnt_idx = '0;
        any_req = 1'b0;
        iv      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            iv = IDW'((int'(last_grant) + k) % N_REQ);
            if (!any_req && req_bus.req_valid[iv]) begin
                any_req = 1'b1;
                gnt_idx = iv;
            end
        end
    end

    assign gnt_oh = N_REQ'(1) << gnt_idx;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        roundpack_req_slice u_lane (
            .sel  (gnt_oh[i]),
            .sign (req_bus.req_sign[i]),
            .exp  (req_bus.req_exp[12*i +: 12]),
            .sig  (req_bus.req_sig[64*i +: 64]),
            .op   (lane_op[i])
        );
    end

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < N_REQ; i++) sel_op = sel_op | lane_op[i];
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        cap_done  = 1'b0;
        rsp_hs    = 1'b0;
        ap_start  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // Gated by reset so no accept pulse escapes while reset is held.
                if (any_req && ap_rst_n) begin
                    accept   = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ap_start = 1'b1;
                if (core.u_ap_ready) begin
                    if (core.u_ap_done) begin
                        cap_done = 1'b1;
                        state_nx = S_RESP;
                    end else begin
                        state_nx = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core.u_ap_done) begin
                    cap_done = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (req_bus.rsp_ready) begin
                    rsp_hs   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign flag_wb = core.u_flag_o_vld && (state == S_ISSUE || state == S_WAIT);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            last_grant <= IDW'(N_REQ - 1);
            gnt_q      <= '0;
            z_sign     <= 1'b0;
            z_exp      <= '0;
            z_sig      <= '0;
            flag_q     <= '0;
            flag_snap  <= '0;
            rsp_flags  <= '0;
            rsp_data   <= '0;
        end else begin
            if (accept) begin
                gnt_q                 <= gnt_idx;
                {z_sign, z_exp, z_sig} <= sel_op;
                flag_snap             <= flag_q;
                rsp_flags             <= '0;
            end
            if (cap_done) rsp_data <= core.u_ap_return;
            // Only bits this operation raised are reported; the core's write wins over a clear.
            if (flag_wb) begin
                rsp_flags <= core.u_flag_o & ~flag_snap;
                flag_q    <= core.u_flag_o;
            end else if (req_bus.flag_clr) begin
                flag_q    <= '0;
            end
            if (rsp_hs) last_grant <= gnt_q;
        end
    end

    assign req_bus.req_ready = accept ? gnt_oh : '0;
    assign req_bus.rsp_valid = rsp_valid;
    assign req_bus.rsp_id    = gnt_q;
    assign req_bus.rsp_data  = rsp_data;
    assign req_bus.rsp_flags = rsp_flags;
    assign req_bus.flag_q    = flag_q;

    assign core.u_ap_start = ap_start;
    assign core.u_zSign    = z_sign;
    assign core.u_zExp     = z_exp;
    assign core.u_zSig     = z_sig;
    assign core.u_flag_i   = flag_q;

    assign unused_core_idle = core.u_ap_idle;
endmodule

// File: tb/tb_roundpack_add_arbiter.sv
// Bench for roundpack_add_arbiter: behavioural core stub with programmable latency and
// a high-level round-robin / sticky-flag reference model.
module tb_roundpack_add_arbiter;
    localparam int N   = 4;
    localparam int FW  = 32;
    localparam int IDW = $clog2(N);

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    roundpack_req_if  #(.N_REQ(N), .FLAG_W(FW)) rq ();
    roundpack_core_if #(.FLAG_W(FW))             cr ();

    roundpack_add_arbiter #(.N_REQ(N), .FLAG_W(FW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .req_bus  (rq),
        .core     (cr)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Core stub: accepts ap_start at once, done `lat` cycles after ready (0 = same cycle).
    int unsigned    lat = 0;
    int             cnt = 0;
    logic           busy = 1'b0;
    logic           late_done = 1'b0;
    logic [FW-1:0]  raise = '0;
    logic           vld_en = 1'b0;
    logic           clr_man = 1'b0;
    logic           clr_on_done = 1'b0;
    logic           core_done;

    function automatic logic [63:0] ref_pack(input logic s, input logic [11:0] e, input logic [63:0] m);
        logic [63:0] r;
        r = (m + 64'h200) >> 10;
        if (m[9:0] == 10'h200) r[0] = 1'b0;
        return {s, 63'b0} + ({52'b0, e} << 52) + r;
    endfunction

    assign cr.u_ap_ready   = cr.u_ap_start && !busy;
    assign core_done       = (cr.u_ap_ready && lat == 0) || (busy && cnt == 1) || late_done;
    assign cr.u_ap_done    = core_done;
    assign cr.u_ap_idle    = !busy;
    assign cr.u_ap_return  = ref_pack(cr.u_zSign, cr.u_zExp, cr.u_zSig);
    assign cr.u_flag_o     = cr.u_flag_i | raise;
    assign cr.u_flag_o_vld = core_done && vld_en;
    assign rq.flag_clr     = clr_man | (clr_on_done & core_done);

    always @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            busy <= 1'b0;
            cnt  <= 0;
        end else if (busy) begin
            cnt <= cnt - 1;
            if (cnt == 1) busy <= 1'b0;
        end else if (cr.u_ap_start && lat != 0) begin
            busy <= 1'b1;
            cnt  <= int'(lat);
        end
    end

    // Reference model state
    logic          op_s [N];
    logic [11:0]   op_e [N];
    logic [63:0]   op_m [N];
    int            last_g = N - 1;
    logic [FW-1:0] sticky = '0;

    function automatic int exp_grant(input int last, input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op_s[i] = 1'($urandom_range(0, 1));
            op_e[i] = 12'($urandom_range(1, 12'h7FC));
            op_m[i] = {$urandom, $urandom};
        end
    endtask

    task automatic apply_ops();
        for (int i = 0; i < N; i++) begin
            rq.req_sign[i]        = op_s[i];
            rq.req_exp[12*i +: 12] = op_e[i];
            rq.req_sig[64*i +: 64] = op_m[i];
        end
    endtask

    // Drives one operation to completion; called and returns at posedge+1.
    task automatic run_op(input logic [N-1:0] mask, input int unsigned l, input logic [FW-1:0] rz,
                          input logic ve, output logic [N-1:0] rdy, output int pulses, output logic got,
                          output logic [IDW-1:0] id, output logic [63:0] data,
                          output logic [FW-1:0] flags, output logic [FW-1:0] fq);
        lat = l; raise = rz; vld_en = ve;
        rq.rsp_ready = 1'b1;
        rq.req_valid = mask;
        apply_ops();
        pulses = 0; rdy = '0; got = 1'b0;
        id = 'x; data = 'x; flags = 'x; fq = 'x;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (rq.req_ready != '0) begin pulses++; rdy = rq.req_ready; end
            if (rq.rsp_valid) begin
                got = 1'b1; id = rq.rsp_id; data = rq.rsp_data;
                flags = rq.rsp_flags; fq = rq.flag_q;
            end
            @(posedge ap_clk); #1;
        end
        rq.req_valid = '0;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        rq.req_valid = '1;
        repeat (2) @(posedge ap_clk);
        #1;
        n_chk++; if (rq.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got=%b want=0", rq.req_ready); end
        n_chk++; if (rq.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rq.rsp_valid); end
        n_chk++; if (rq.flag_q !== '0) begin n_fail++; $display("FAIL reset_flag_q got=%h want=0", rq.flag_q); end
        n_chk++; if (cr.u_ap_start !== 1'b0) begin n_fail++; $display("FAIL reset_ap_start got=%b want=0", cr.u_ap_start); end
        n_chk++; if (rq.rsp_data !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h want=0", rq.rsp_data); end
        n_chk++; if (cr.u_zSig !== 64'h0) begin n_fail++; $display("FAIL reset_zsig got=%h want=0", cr.u_zSig); end
        ap_rst_n = 1'b1;
        rq.req_valid = '0;
        @(posedge ap_clk); #1;
        last_g = N - 1; sticky = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] rdy; int pulses; logic got; logic [IDW-1:0] id;
        logic [63:0] data; logic [FW-1:0] flags, fq; logic [N-1:0] want;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            run_op('1, $urandom_range(0, 5), '0, 1'b0, rdy, pulses, got, id, data, flags, fq);
            want = N'(1) << (k % N);
            n_chk++; if (!got) begin n_fail++; $display("FAIL rr_timeout op=%0d got=no_rsp want=rsp", k); end
            n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL rr_pulses op=%0d got=%0d want=1", k, pulses); end
            n_chk++; if (rdy !== want) begin n_fail++; $display("FAIL rr_grant op=%0d got=%b want=%b", k, rdy, want); end
            n_chk++; if (id !== IDW'(k % N)) begin n_fail++; $display("FAIL rr_id op=%0d got=%0d want=%0d", k, id, k % N); end
            n_chk++; if (data !== ref_pack(op_s[k%N], op_e[k%N], op_m[k%N])) begin
                n_fail++; $display("FAIL rr_data op=%0d got=%h want=%h", k, data, ref_pack(op_s[k%N], op_e[k%N], op_m[k%N])); end
        end
        last_g = (8 - 1) % N;
    endtask

    task automatic test_single();
        logic [N-1:0] rdy; int pulses; logic got; logic [IDW-1:0] id;
        logic [63:0] data; logic [FW-1:0] flags, fq;
        rand_ops();
        op_s[0] = 1'b0; op_e[0] = 12'h3FE; op_m[0] = 64'h4000000000000000;
        run_op(4'b0001, 1, '0, 1'b0, rdy, pulses, got, id, data, flags, fq);
        n_chk++; if (!got) begin n_fail++; $display("FAIL single_timeout got=no_rsp want=rsp"); end
        n_chk++; if (id !== '0) begin n_fail++; $display("FAIL single_id got=%0d want=0", id); end
        n_chk++; if (data !== 64'h3FF0000000000000) begin n_fail++; $display("FAIL single_data got=%h want=3ff0000000000000", data); end
        n_chk++; if (flags !== '0) begin n_fail++; $display("FAIL single_flags got=%h want=0", flags); end
        n_chk++; if (rdy !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b want=0001", rdy); end
        last_g = 0;
    endtask

    task automatic test_flags();
        logic [N-1:0] rdy; int pulses; logic got; logic [IDW-1:0] id;
        logic [63:0] data; logic [FW-1:0] flags, fq;
        rand_ops();
        run_op(4'b0010, 2, 32'h1, 1'b1, rdy, pulses, got, id, data, flags, fq);
        n_chk++; if (flags !== 32'h1) begin n_fail++; $display("FAIL flagsA_rsp got=%h want=1", flags); end
        n_chk++; if (fq !== 32'h1) begin n_fail++; $display("FAIL flagsA_q got=%h want=1", fq); end
        run_op(4'b0010, 0, 32'h5, 1'b1, rdy, pulses, got, id, data, flags, fq);
        n_chk++; if (flags !== 32'h4) begin n_fail++; $display("FAIL flagsB_rsp got=%h want=4", flags); end
        n_chk++; if (fq !== 32'h5) begin n_fail++; $display("FAIL flagsB_q got=%h want=5", fq); end
        last_g = 1; sticky = 32'h5;
    endtask

    task automatic test_flag_clr();
        logic [N-1:0] rdy; int pulses; logic got; logic [IDW-1:0] id;
        logic [63:0] data; logic [FW-1:0] flags, fq;
        clr_man = 1'b1; @(posedge ap_clk); #1; clr_man = 1'b0;
        n_chk++; if (rq.flag_q !== '0) begin n_fail++; $display("FAIL clr_first got=%h want=0", rq.flag_q); end
        clr_on_done = 1'b1;
        run_op(4'b1000, 3, 32'h2, 1'b1, rdy, pulses, got, id, data, flags, fq);
        clr_on_done = 1'b0;
        n_chk++; if (fq !== 32'h2) begin n_fail++; $display("FAIL clr_vs_vld_q got=%h want=2", fq); end
        n_chk++; if (flags !== 32'h2) begin n_fail++; $display("FAIL clr_vs_vld_rsp got=%h want=2", flags); end
        clr_man = 1'b1; @(posedge ap_clk); #1; clr_man = 1'b0;
        n_chk++; if (rq.flag_q !== '0) begin n_fail++; $display("FAIL clr_alone got=%h want=0", rq.flag_q); end
        last_g = 3; sticky = '0;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] rdy; int pulses; logic got; logic [IDW-1:0] id, id0;
        logic [63:0] data, d0; logic [FW-1:0] flags, fq, f0; int g, g2; logic [N-1:0] want;
        rand_ops(); apply_ops();
        lat = 2; raise = '0; vld_en = 1'b0;
        rq.rsp_ready = 1'b0;
        rq.req_valid = 4'b0011;
        g = exp_grant(last_g, 4'b0011);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge ap_clk); #1;
            got = rq.rsp_valid;
        end
        n_chk++; if (!got) begin n_fail++; $display("FAIL bp_timeout got=no_rsp want=rsp"); end
        id0 = rq.rsp_id; d0 = rq.rsp_data; f0 = rq.rsp_flags;
        n_chk++; if (id0 !== IDW'(g)) begin n_fail++; $display("FAIL bp_id got=%0d want=%0d", id0, g); end
        n_chk++; if (d0 !== ref_pack(op_s[g], op_e[g], op_m[g])) begin n_fail++; $display("FAIL bp_data got=%h want=%h", d0, ref_pack(op_s[g], op_e[g], op_m[g])); end
        for (int c = 0; c < 10; c++) begin
            @(posedge ap_clk); #1;
            n_chk++; if (!rq.rsp_valid || rq.rsp_id !== id0 || rq.rsp_data !== d0 || rq.rsp_flags !== f0 || rq.req_ready !== '0) begin
                n_fail++; $display("FAIL bp_hold cyc=%0d got=v%b id%0d d%h rdy%b want=v1 id%0d d%h rdy0", c, rq.rsp_valid, rq.rsp_id, rq.rsp_data, rq.req_ready, id0, d0); end
        end
        rq.rsp_ready = 1'b1;
        @(posedge ap_clk); #1;
        last_g = g;
        g2 = exp_grant(last_g, 4'b0011);
        want = N'(1) << g2;
        n_chk++; if (rq.req_ready !== want) begin n_fail++; $display("FAIL bp_next_grant got=%b want=%b", rq.req_ready, want); end
        run_op(4'b0011, 1, '0, 1'b0, rdy, pulses, got, id, data, flags, fq);
        n_chk++; if (id !== IDW'(g2)) begin n_fail++; $display("FAIL bp_next_id got=%0d want=%0d", id, g2); end
        last_g = g2;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rdy; int pulses; logic got; logic [IDW-1:0] id;
        logic [63:0] data; logic [FW-1:0] flags, fq; logic seen;
        rand_ops(); apply_ops();
        lat = 5; raise = 32'h10; vld_en = 1'b1;
        rq.rsp_ready = 1'b1;
        rq.req_valid = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1; seen = (rq.req_ready != '0);
            @(posedge ap_clk); #1;
        end
        n_chk++; if (!seen) begin n_fail++; $display("FAIL rst_mid_accept got=no_ready want=ready"); end
        rq.req_valid = '0;
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        n_chk++; if (rq.rsp_valid !== 1'b0 || rq.req_ready !== '0 || cr.u_ap_start !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl got=v%b r%b s%b want=0", rq.rsp_valid, rq.req_ready, cr.u_ap_start); end
        n_chk++; if (rq.rsp_data !== '0 || rq.rsp_flags !== '0 || rq.rsp_id !== '0 || rq.flag_q !== '0) begin
            n_fail++; $display("FAIL rst_mid_rsp got=d%h f%h id%0d q%h want=0", rq.rsp_data, rq.rsp_flags, rq.rsp_id, rq.flag_q); end
        n_chk++; if (cr.u_zExp !== '0 || cr.u_zSig !== '0 || cr.u_zSign !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ops got=e%h m%h want=0", cr.u_zExp, cr.u_zSig); end
        ap_rst_n = 1'b1;
        late_done = 1'b1;
        @(posedge ap_clk); #1;
        late_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_chk++; if (rq.rsp_valid !== 1'b0 || rq.flag_q !== '0) begin
                n_fail++; $display("FAIL rst_mid_late cyc=%0d got=v%b q%h want=v0 q0", c, rq.rsp_valid, rq.flag_q); end
            @(posedge ap_clk); #1;
        end
        last_g = N - 1; sticky = '0;
        run_op('1, 0, '0, 1'b0, rdy, pulses, got, id, data, flags, fq);
        n_chk++; if (id !== '0 || rdy !== 4'b0001) begin n_fail++; $display("FAIL rst_mid_regrant got=id%0d r%b want=id0 r0001", id, rdy); end
        last_g = 0;
    endtask

    task automatic test_random();
        logic [N-1:0] rdy; int pulses; logic got; logic [IDW-1:0] id;
        logic [63:0] data; logic [FW-1:0] flags, fq, rz, ef;
        logic [N-1:0] mask; logic ve; int g;
        for (int k = 0; k < 24; k++) begin
            rand_ops();
            mask = N'($urandom_range(1, (1 << N) - 1));
            rz   = FW'($urandom_range(0, 15));
            ve   = 1'($urandom_range(0, 1));
            g    = exp_grant(last_g, mask);
            run_op(mask, $urandom_range(0, 5), rz, ve, rdy, pulses, got, id, data, flags, fq);
            ef = ve ? ((sticky | rz) & ~sticky) : '0;
            if (ve) sticky = sticky | rz;
            n_chk++; if (!got || pulses != 1 || rdy !== (N'(1) << g)) begin
                n_fail++; $display("FAIL rnd_grant op=%0d got=rsp%b p%0d r%b want=rsp1 p1 r%b", k, got, pulses, rdy, N'(1) << g); end
            n_chk++; if (id !== IDW'(g)) begin n_fail++; $display("FAIL rnd_id op=%0d got=%0d want=%0d", k, id, g); end
            n_chk++; if (data !== ref_pack(op_s[g], op_e[g], op_m[g])) begin
                n_fail++; $display("FAIL rnd_data op=%0d got=%h want=%h", k, data, ref_pack(op_s[g], op_e[g], op_m[g])); end
            n_chk++; if (flags !== ef || fq !== sticky) begin
                n_fail++; $display("FAIL rnd_flags op=%0d got=f%h q%h want=f%h q%h", k, flags, fq, ef, sticky); end
            last_g = g;
        end
    endtask

    initial begin
        rq.req_valid = '0; rq.req_sign = '0; rq.req_exp = '0; rq.req_sig = '0;
        rq.rsp_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_single();
        test_flags();
        test_flag_clr();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
